approx_mult_arbiter: RTL and testbench

APPROX_MULT_ARBITER -- requirements
Module: approx_mult_arbiter

---
 rtl/approx_mult_arbiter.sv | 159 +++++++++++++++
 tb/tb_approx_mult_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_arbiter.sv
// approx_mult_arbiter
// Round-robin front end for a shared external 8x8 approximate multiplier.
// Two requesters compete for a single-entry issue stage (S1); S1 drives the
// multiplier operands and the returned product is folded into a per-requester
// 20-bit accumulator as it moves into the single-entry response stage (S2).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/a/b/acc       requester N operation (acc=1 accumulate, 0 load)
//   reqN_ready               requester N accepted when valid & ready
//   mult_a, mult_b           operands to the shared multiplier (0 when S1 empty)
//   mult_p                   combinational product from the multiplier
//   rsp_valid/id/data        response register contents
//   rsp_ready                consumer accepts response when valid & ready
module approx_mult_arbiter #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_W-1:0]     req0_a,
    input  logic [DATA_W-1:0]     req0_b,
    input  logic                  req0_acc,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_W-1:0]     req1_a,
    input  logic [DATA_W-1:0]     req1_b,
    input  logic                  req1_acc,
    output logic                  req1_ready,
    output logic [DATA_W-1:0]     mult_a,
    output logic [DATA_W-1:0]     mult_b,
    input  logic [2*DATA_W-1:0]   mult_p,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [ACC_W-1:0]      rsp_data,
    input  logic                  rsp_ready
);

    localparam int PROD_W = 2 * DATA_W;

    function automatic logic [ACC_W-1:0] prod_zext(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){1'b0}}, p};
    endfunction

    // Accumulation wraps modulo 2^ACC_W; carry out is deliberately dropped.
    function automatic logic [ACC_W-1:0] acc_wrap_add(input logic [ACC_W-1:0] acc,
                                                      input logic [PROD_W-1:0] p);
        return acc + prod_zext(p);
    endfunction

    logic              s1_vld_q, s1_vld_d;
    logic              s1_id_q, s1_id_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic              s1_acc_q, s1_acc_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic              rsp_id_q, rsp_id_d;
    logic [ACC_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ACC_W-1:0]  acc0_q, acc0_d;
    logic [ACC_W-1:0]  acc1_q, acc1_d;
    // Requester preferred on a tie; cleared so the first tie goes to 0.
    logic              ptr_q, ptr_d;

    logic              s2_free, s1_adv, s1_open;
    logic              win0, win1, grant0, grant1;
    logic [ACC_W-1:0]  acc_cur, acc_new;

    assign s2_free = !rsp_vld_q || rsp_ready;
    assign s1_adv  = s1_vld_q && s2_free;
    assign s1_open = !s1_vld_q || s1_adv;

    // Winner depends only on valids and the pointer, never on operands.
    assign win0 = req0_valid && (!req1_valid || !ptr_q);
    assign win1 = req1_valid && (!req0_valid ||  ptr_q);

    // Gated by rst so nothing is accepted while reset is held.
    assign req0_ready = !rst && s1_open && win0;
    assign req1_ready = !rst && s1_open && win1;
    assign grant0     = req0_valid && req0_ready;
    assign grant1     = req1_valid && req1_ready;

    assign mult_a    = s1_vld_q ? s1_a_q : '0;
    assign mult_b    = s1_vld_q ? s1_b_q : '0;
    assign rsp_valid = rsp_vld_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

    assign acc_cur = s1_id_q ? acc1_q : acc0_q;
    assign acc_new = s1_acc_q ? acc_wrap_add(acc_cur, mult_p) : prod_zext(mult_p);

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_id_d    = s1_id_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_acc_d   = s1_acc_q;
        rsp_vld_d  = rsp_vld_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        ptr_d      = ptr_q;

        // S1 -> S2: the accumulator is written in the same cycle the response
        // is captured, so the next op from the same requester (now in S1)
        // already reads the updated value.
        if (s1_adv) begin
            rsp_vld_d  = 1'b1;
            rsp_id_d   = s1_id_q;
            rsp_data_d = acc_new;
            if (s1_id_q) acc1_d = acc_new;
            else         acc0_d = acc_new;
        end else if (rsp_ready) begin
            rsp_vld_d = 1'b0;
        end

        // Request -> S1
        if (grant0 || grant1) begin
            s1_vld_d = 1'b1;
            s1_id_d  = grant1;
            s1_a_d   = grant1 ? req1_a   : req0_a;
            s1_b_d   = grant1 ? req1_b   : req0_b;
            s1_acc_d = grant1 ? req1_acc : req0_acc;
            ptr_d    = grant0;
        end else if (s1_adv) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_acc_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            ptr_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_id_q    <= s1_id_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_acc_q   <= s1_acc_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            ptr_q      <= ptr_d;
        end
    end

endmodule

// File: tb/tb_approx_mult_arbiter.sv
module tb_approx_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_acc, req0_ready;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_acc, req1_ready;
    logic [7:0]  req1_a, req1_b;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_p;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [19:0] rsp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    int n0;
    logic [19:0] last_data;
    logic        last_id;

    // Reference: {id, data} per granted op, accumulators per requester.
    logic [20:0] exp_q[$];
    logic [19:0] m_acc0, m_acc1;

    always #5 clk = ~clk;

    // Exact multiplier model standing in for the Wallace tree.
    assign mult_p = {8'd0, mult_a} * {8'd0, mult_b};

    approx_mult_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_acc(req0_acc), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_acc(req1_acc), .req1_ready(req1_ready),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_grant(input logic id, input logic [7:0] a, input logic [7:0] b,
                               input logic acc);
        logic [19:0] p, v;
        p = {4'd0, {8'd0, a} * {8'd0, b}};
        v = acc ? ((id ? m_acc1 : m_acc0) + p) : p;
        if (id) m_acc1 = v; else m_acc0 = v;
        exp_q.push_back({id, v});
    endtask

    // Handshakes are stable between posedge+1 and the next posedge, so the
    // falling edge sees exactly the transfers that the next rising edge makes.
    initial begin
        logic [20:0] e;
        m_acc0 = '0;
        m_acc1 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                m_acc0 = '0;
                m_acc1 = '0;
            end else begin
                if (rsp_valid && rsp_ready) begin
                    n_rsp++;
                    last_data = rsp_data;
                    last_id   = rsp_id;
                    check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_rsp_id", 32'(rsp_id), 32'(e[20]));
                        check("sb_rsp_data", 32'(rsp_data), 32'(e[19:0]));
                    end
                end
                if (req0_valid && req0_ready) model_grant(1'b0, req0_a, req0_b, req0_acc);
                if (req1_valid && req1_ready) model_grant(1'b1, req1_a, req1_b, req1_acc);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9; req0_acc = 1'b0;
        req1_valid = 1'b1; req1_a = 8'd9; req1_b = 8'd9; req1_acc = 1'b0;
        rsp_ready = 1'b1;

        // Reset state with both requesters asking
        cyc(); cyc(); #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mult_a", 32'(mult_a), 32'd0);
        check("rst_mult_b", 32'(mult_b), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        cyc();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // Single op 200*100 = 20000, one cycle after grant
        req0_valid = 1'b1; req0_a = 8'd200; req0_b = 8'd100; req0_acc = 1'b0;
        #1;
        check("single_ready0", 32'(req0_ready), 32'd1);
        check("single_ready1", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        #1;
        check("single_mult_a", 32'(mult_a), 32'd200);
        check("single_mult_b", 32'(mult_b), 32'd100);
        check("single_rsp_early", 32'(rsp_valid), 32'd0);
        cyc(); #1;
        check("single_rsp_valid", 32'(rsp_valid), 32'd1);
        check("single_rsp_id", 32'(rsp_id), 32'd0);
        check("single_rsp_data", 32'(rsp_data), 32'd20000);
        cyc();

        // Accumulate wrap: 17 * 65025 = 1105425; mod 2^20 = 56849
        for (int i = 0; i < 17; i++) begin
            req1_valid = 1'b1; req1_a = 8'd255; req1_b = 8'd255; req1_acc = (i != 0);
            #1;
            check("wrap_ready1", 32'(req1_ready), 32'd1);
            cyc();
        end
        req1_valid = 1'b0;
        repeat (3) cyc();
        check("wrap_final", 32'(last_data), 32'd56849);
        check("wrap_id", 32'(last_id), 32'd1);

        // Accumulator 0 untouched: 20000 + 0*0
        req0_valid = 1'b1; req0_a = 8'd0; req0_b = 8'd0; req0_acc = 1'b1;
        #1;
        check("acc0_ready0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        repeat (3) cyc();
        check("acc0_unchanged", 32'(last_data), 32'd20000);
        check("acc0_id", 32'(last_id), 32'd0);

        // Fairness after reset: 0,1,0,1,...
        rst = 1'b1;
        #1;
        check("rst2_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1'b1; req0_a = 8'(i + 1); req0_b = 8'd3; req0_acc = 1'b0;
            req1_valid = 1'b1; req1_a = 8'(i + 2); req1_b = 8'd5; req1_acc = 1'b0;
            #1;
            check("fair_ready0", 32'(req0_ready), 32'(i % 2 == 0));
            check("fair_ready1", 32'(req1_ready), 32'(i % 2 == 1));
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) cyc();

        // Backpressure: A=10*10 (req0), B=7*3 (req1), C=2*5 acc on req0 -> 110
        n0 = n_rsp;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd10; req0_b = 8'd10; req0_acc = 1'b0;
        req1_valid = 1'b1; req1_a = 8'd7;  req1_b = 8'd3;  req1_acc = 1'b0;
        #1;
        check("bp_grant_a", 32'(req0_ready), 32'd1);
        cyc();
        req0_a = 8'd2; req0_b = 8'd5; req0_acc = 1'b1;
        #1;
        check("bp_grant_b", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready0", 32'(req0_ready), 32'd0);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'd100);
            check("bp_s1_hold", 32'(mult_a), 32'd7);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        repeat (4) cyc();
        check("bp_rsp_count", 32'(n_rsp - n0), 32'd3);
        check("bp_last_data", 32'(last_data), 32'd110);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with S1 and S2 full
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_acc = 1'b0;
        cyc(); cyc();
        #1;
        check("mid_s2_full", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_ready0", 32'(req0_ready), 32'd0);
        check("mid_mult_a", 32'(mult_a), 32'd0);
        cyc();
        rst = 1'b0; req0_valid = 1'b0; rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4; req1_acc = 1'b1;
        #1;
        check("mid_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        cyc(); #1;
        check("mid_acc1_rsp", 32'(rsp_data), 32'd12);
        check("mid_acc1_id", 32'(rsp_id), 32'd1);
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_acc = 1'b1;
        cyc();
        req0_valid = 1'b0;
        cyc(); #1;
        check("mid_acc0_rsp", 32'(rsp_data), 32'd1);
        cyc();

        // Random traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_acc = 1'($urandom_range(0, 1));
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_acc = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("rand_one_ready", 32'(req0_ready && req1_ready), 32'd0);
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (5) cyc();
        check("rand_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
